// File: rtl/antilog_arbiter.sv
// Round-robin sharing of one antilog converter between the pitch (ch0) and volume (ch1)
// channels, with per-channel pending samples and a watchdog on the converter reply.
module antilog_arbiter #(
    parameter int IN_B    = 16,
    parameter int OUT_B   = 12,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [IN_B-1:0]  ch0_data,
    input  logic             ch0_valid,
    input  logic [IN_B-1:0]  ch1_data,
    input  logic             ch1_valid,
    output logic [IN_B-1:0]  conv_data,
    output logic             conv_valid,
    input  logic [OUT_B-1:0] conv_result,
    input  logic             conv_result_valid,
    output logic [OUT_B-1:0] ch0_out,
    output logic [OUT_B-1:0] ch1_out,
    output logic             ch0_out_valid,
    output logic             ch1_out_valid,
    output logic             ch0_drop,
    output logic             ch1_drop,
    output logic             timeout_err
);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state, state_n;
    logic            grant, grant_n;
    logic            last_grant, last_grant_n;
    logic [TW-1:0]   timer, timer_n;
    logic            pend0, pend0_n, pend1, pend1_n;
    logic [IN_B-1:0] hold0, hold0_n, hold1, hold1_n;
    logic            issue0, issue1, sel;

    logic [IN_B-1:0]  conv_data_n;
    logic             conv_valid_n;
    logic [OUT_B-1:0] ch0_out_n, ch1_out_n;
    logic             ch0_out_valid_n, ch1_out_valid_n;
    logic             ch0_drop_n, ch1_drop_n, timeout_err_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            grant         <= 1'b0;
            last_grant    <= 1'b1;
            timer         <= '0;
            pend0         <= 1'b0;
            pend1         <= 1'b0;
            hold0         <= '0;
            hold1         <= '0;
            conv_data     <= '0;
            conv_valid    <= 1'b0;
            ch0_out       <= '0;
            ch1_out       <= '0;
            ch0_out_valid <= 1'b0;
            ch1_out_valid <= 1'b0;
            ch0_drop      <= 1'b0;
            ch1_drop      <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            state         <= state_n;
            grant         <= grant_n;
            last_grant    <= last_grant_n;
            timer         <= timer_n;
            pend0         <= pend0_n;
            pend1         <= pend1_n;
            hold0         <= hold0_n;
            hold1         <= hold1_n;
            conv_data     <= conv_data_n;
            conv_valid    <= conv_valid_n;
            ch0_out       <= ch0_out_n;
            ch1_out       <= ch1_out_n;
            ch0_out_valid <= ch0_out_valid_n;
            ch1_out_valid <= ch1_out_valid_n;
            ch0_drop      <= ch0_drop_n;
            ch1_drop      <= ch1_drop_n;
            timeout_err   <= timeout_err_n;
        end
    end

    always_comb begin
        state_n         = state;
        grant_n         = grant;
        last_grant_n    = last_grant;
        timer_n         = timer;
        conv_data_n     = conv_data;
        conv_valid_n    = 1'b0;
        ch0_out_n       = ch0_out;
        ch1_out_n       = ch1_out;
        ch0_out_valid_n = 1'b0;
        ch1_out_valid_n = 1'b0;
        timeout_err_n   = 1'b0;
        issue0          = 1'b0;
        issue1          = 1'b0;
        sel             = 1'b0;

        case (state)
            IDLE: begin
                if (pend0 || pend1) begin
                    // On a tie the channel that did not go last wins.
                    sel          = (pend0 && pend1) ? ~last_grant : pend1;
                    conv_data_n  = sel ? hold1 : hold0;
                    conv_valid_n = 1'b1;
                    grant_n      = sel;
                    timer_n      = '0;
                    issue0       = ~sel;
                    issue1       = sel;
                    state_n      = WAIT;
                end
            end
            WAIT: begin
                if (timer != '1) timer_n = timer + 1'b1;
                if (conv_result_valid) begin
                    if (grant) begin
                        ch1_out_n       = conv_result;
                        ch1_out_valid_n = 1'b1;
                    end else begin
                        ch0_out_n       = conv_result;
                        ch0_out_valid_n = 1'b1;
                    end
                    last_grant_n = grant;
                    state_n      = IDLE;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    timeout_err_n = 1'b1;
                    last_grant_n  = grant;
                    state_n       = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // A sample arriving on its channel's issue edge stays pending; the old hold is what goes out.
        pend0_n    = ch0_valid ? 1'b1 : (issue0 ? 1'b0 : pend0);
        pend1_n    = ch1_valid ? 1'b1 : (issue1 ? 1'b0 : pend1);
        hold0_n    = ch0_valid ? ch0_data : hold0;
        hold1_n    = ch1_valid ? ch1_data : hold1;
        ch0_drop_n = ch0_valid && pend0 && !issue0;
        ch1_drop_n = ch1_valid && pend1 && !issue1;
    end
endmodule

// File: tb/tb_antilog_arbiter.sv
// Directed bench for antilog_arbiter with a cycle-stepped converter model (2/5-cycle latency).
module tb_antilog_arbiter;
    localparam int IN_B = 16, OUT_B = 12, TIMEOUT = 16;

    logic clk = 1'b0;
    logic reset_n;
    logic [IN_B-1:0] ch0_data, ch1_data, conv_data;
    logic ch0_valid, ch1_valid, conv_valid, conv_result_valid;
    logic [OUT_B-1:0] conv_result, ch0_out, ch1_out;
    logic ch0_out_valid, ch1_out_valid, ch0_drop, ch1_drop, timeout_err;

    always #5 clk = ~clk;

    antilog_arbiter #(.IN_B(IN_B), .OUT_B(OUT_B), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .ch0_data(ch0_data), .ch0_valid(ch0_valid),
        .ch1_data(ch1_data), .ch1_valid(ch1_valid),
        .conv_data(conv_data), .conv_valid(conv_valid),
        .conv_result(conv_result), .conv_result_valid(conv_result_valid),
        .ch0_out(ch0_out), .ch1_out(ch1_out),
        .ch0_out_valid(ch0_out_valid), .ch1_out_valid(ch1_out_valid),
        .ch0_drop(ch0_drop), .ch1_drop(ch1_drop), .timeout_err(timeout_err)
    );

    int checks = 0, errors = 0;
    int cyc = 0;
    int cnt = -1;
    logic conv_en = 1'b1;
    logic [IN_B-1:0] req = '0;
    int cv_cyc[$], cv_dat[$], o0_cyc[$], o1_cyc[$], d0_cyc[$], d1_cyc[$], tmo_cyc[$];

    typedef struct {
        logic        ch;
        logic [15:0] data;
        int          lat;
        logic [11:0] res;
    } vec_t;
    vec_t vt[6];

    // Converter stand-in: inputs below 2048 saturate to 0 after 2 cycles, others answer after 5.
    function automatic logic [11:0] conv_fn(input logic [15:0] d);
        if (d < 16'd2048) return 12'h000;
        if (d == 16'd3102) return 12'h1C7;
        return d[11:0];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        conv_result_valid = 1'b0;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                conv_result_valid = conv_en;
                conv_result       = conv_fn(req);
                cnt               = -1;
            end
        end
        if (conv_valid) begin
            req = conv_data;
            cnt = (conv_data < 16'd2048) ? 2 : 5;
            cv_cyc.push_back(cyc);
            cv_dat.push_back(int'(conv_data));
        end
        if (ch0_out_valid) o0_cyc.push_back(cyc);
        if (ch1_out_valid) o1_cyc.push_back(cyc);
        if (ch0_drop)      d0_cyc.push_back(cyc);
        if (ch1_drop)      d1_cyc.push_back(cyc);
        if (timeout_err)   tmo_cyc.push_back(cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic clr();
        cv_cyc.delete(); cv_dat.delete(); o0_cyc.delete(); o1_cyc.delete();
        d0_cyc.delete(); d1_cyc.delete(); tmo_cyc.delete();
    endtask

    task automatic pulse(input logic ch, input logic [15:0] d);
        if (ch) begin ch1_valid = 1'b1; ch1_data = d; end
        else    begin ch0_valid = 1'b1; ch0_data = d; end
        tick();
        ch0_valid = 1'b0;
        ch1_valid = 1'b0;
    endtask

    task automatic both(input logic [15:0] d0, input logic [15:0] d1);
        ch0_valid = 1'b1; ch0_data = d0;
        ch1_valid = 1'b1; ch1_data = d1;
        tick();
        ch0_valid = 1'b0;
        ch1_valid = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_conv_valid"}, int'(conv_valid), 0);
        check({tag, "_conv_data"}, int'(conv_data), 0);
        check({tag, "_ch0_out"}, int'(ch0_out), 0);
        check({tag, "_ch1_out"}, int'(ch1_out), 0);
        check({tag, "_pulses"}, int'({ch0_out_valid, ch1_out_valid, ch0_drop, ch1_drop, timeout_err}), 0);
    endtask

    initial begin
        int base, own_n, own_c, oth_n;
        reset_n = 1'b0;
        ch0_valid = 1'b0; ch1_valid = 1'b0; ch0_data = '0; ch1_data = '0;
        conv_result = '0; conv_result_valid = 1'b0;
        vt[0] = '{1'b0, 16'd3102,  8, 12'h1C7};
        vt[1] = '{1'b0, 16'd1000,  5, 12'h000};
        vt[2] = '{1'b1, 16'd3300,  8, 12'hCE4};
        vt[3] = '{1'b1, 16'd500,   5, 12'h000};
        vt[4] = '{1'b0, 16'd65535, 8, 12'hFFF};
        vt[5] = '{1'b1, 16'd2048,  8, 12'h800};

        idle(2);
        check_zero_outputs("reset");
        reset_n = 1'b1;
        idle(1);

        // Simultaneous arrival straight after reset: ch0 wins, ch1 follows at result + 2.
        clr(); base = cyc;
        both(16'd3200, 16'd3300);
        idle(16);
        check("sim_cv_count", cv_cyc.size(), 2);
        check("sim_cv0_cyc", (cv_cyc.size() > 0) ? cv_cyc[0] - base : -1, 2);
        check("sim_cv0_data", (cv_dat.size() > 0) ? cv_dat[0] : -1, 3200);
        check("sim_cv1_cyc", (cv_cyc.size() > 1) ? cv_cyc[1] - base : -1, 9);
        check("sim_cv1_data", (cv_dat.size() > 1) ? cv_dat[1] : -1, 3300);
        check("sim_o0_cyc", (o0_cyc.size() == 1) ? o0_cyc[0] - base : -1, 8);
        check("sim_o1_cyc", (o1_cyc.size() == 1) ? o1_cyc[0] - base : -1, 15);
        check("sim_ch0_out", int'(ch0_out), 'hC80);
        check("sim_ch1_out", int'(ch1_out), 'hCE4);

        // Second tie: ch1 went last, so ch0 wins again.
        clr(); base = cyc;
        both(16'd3102, 16'd1000);
        idle(16);
        check("tie2_cv0_data", (cv_dat.size() > 0) ? cv_dat[0] : -1, 3102);
        check("tie2_cv1_data", (cv_dat.size() > 1) ? cv_dat[1] : -1, 1000);
        check("tie2_cv1_cyc", (cv_cyc.size() > 1) ? cv_cyc[1] - base : -1, 9);
        check("tie2_o1_cyc", (o1_cyc.size() == 1) ? o1_cyc[0] - base : -1, 12);
        check("tie2_ch0_out", int'(ch0_out), 'h1C7);
        check("tie2_ch1_out", int'(ch1_out), 0);

        for (int i = 0; i < 6; i++) begin
            clr(); base = cyc;
            pulse(vt[i].ch, vt[i].data);
            idle(14);
            own_n = vt[i].ch ? o1_cyc.size() : o0_cyc.size();
            own_c = vt[i].ch ? ((o1_cyc.size() > 0) ? o1_cyc[0] : -1000)
                             : ((o0_cyc.size() > 0) ? o0_cyc[0] : -1000);
            oth_n = vt[i].ch ? o0_cyc.size() : o1_cyc.size();
            check($sformatf("vec%0d_cv_count", i), cv_cyc.size(), 1);
            check($sformatf("vec%0d_cv_cyc", i), (cv_cyc.size() > 0) ? cv_cyc[0] - base : -1, 2);
            check($sformatf("vec%0d_cv_data", i), (cv_dat.size() > 0) ? cv_dat[0] : -1, int'(vt[i].data));
            check($sformatf("vec%0d_out_count", i), own_n, 1);
            check($sformatf("vec%0d_out_lat", i), own_c - base, vt[i].lat);
            check($sformatf("vec%0d_out_val", i), int'(vt[i].ch ? ch1_out : ch0_out), int'(vt[i].res));
            check($sformatf("vec%0d_quiet", i), oth_n + d0_cyc.size() + d1_cyc.size() + tmo_cyc.size(), 0);
        end

        // Overwrite of a pending ch1 sample while ch0 is in flight.
        clr(); base = cyc;
        pulse(1'b0, 16'd3102);
        idle(2);
        pulse(1'b1, 16'd4000);
        idle(1);
        pulse(1'b1, 16'd4100);
        idle(12);
        check("ovw_drop1_count", d1_cyc.size(), 1);
        check("ovw_drop1_cyc", (d1_cyc.size() > 0) ? d1_cyc[0] - base : -1, 6);
        check("ovw_drop0_count", d0_cyc.size(), 0);
        check("ovw_cv_count", cv_cyc.size(), 2);
        check("ovw_cv1_data", (cv_dat.size() > 1) ? cv_dat[1] : -1, 4100);
        check("ovw_cv1_cyc", (cv_cyc.size() > 1) ? cv_cyc[1] - base : -1, 9);
        check("ovw_o1_cyc", (o1_cyc.size() == 1) ? o1_cyc[0] - base : -1, 15);
        check("ovw_ch1_out", int'(ch1_out), 'h004);

        // Watchdog: converter silent for ch0, ch1 pending behind it is then served.
        conv_en = 1'b0;
        clr(); base = cyc;
        pulse(1'b0, 16'd3300);
        pulse(1'b1, 16'd1000);
        idle(16);
        conv_en = 1'b1;
        idle(6);
        check("tmo_count", tmo_cyc.size(), 1);
        check("tmo_after_cv", (tmo_cyc.size() > 0 && cv_cyc.size() > 0) ? tmo_cyc[0] - cv_cyc[0] : -1, 16);
        check("tmo_next_cv_cyc", (cv_cyc.size() > 1) ? cv_cyc[1] - base : -1, 19);
        check("tmo_next_cv_data", (cv_dat.size() > 1) ? cv_dat[1] : -1, 1000);
        check("tmo_o0_count", o0_cyc.size(), 0);
        check("tmo_o1_cyc", (o1_cyc.size() == 1) ? o1_cyc[0] - base : -1, 22);
        check("tmo_ch0_held", int'(ch0_out), 'h1C7);

        // Late result while IDLE must be ignored.
        clr();
        conv_result_valid = 1'b1;
        conv_result = 12'hABC;
        idle(6);
        check("late_no_out", o0_cyc.size() + o1_cyc.size() + cv_cyc.size(), 0);
        check("late_ch0_out", int'(ch0_out), 'h1C7);
        check("late_ch1_out", int'(ch1_out), 0);

        // Reset two cycles into WAIT; the converter's reply arrives afterwards.
        clr(); base = cyc;
        pulse(1'b0, 16'd3102);
        idle(3);
        check("rst_cv_seen", (cv_cyc.size() > 0) ? cv_cyc[0] - base : -1, 2);
        reset_n = 1'b0;
        #1;
        check_zero_outputs("midwait_rst");
        idle(1);
        reset_n = 1'b1;
        idle(8);
        check("rst_no_out", o0_cyc.size() + o1_cyc.size() + tmo_cyc.size(), 0);
        check("rst_ch0_out", int'(ch0_out), 0);
        check("rst_conv_data", int'(conv_data), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
